uart_alu_frame_ctrl: RTL and testbench

- Parametrised successor of the UART-to-ALU interface FSM; sits between the UART RX/TX FIFOs and the combinational ALU.
- Pops operand A, operand B and opcode from the RX FIFO and holds them stable on the ALU inputs.
- Latches the multi-byte ALU result and streams it LSB-first into the TX FIFO, respecting the full flag.
- Aborts partially received frames after a programmable inter-byte timeout.

---
 rtl/uart_alu_pkg.sv | 21 ++
 rtl/uart_alu_timeout_cnt.sv | 49 ++++
 rtl/uart_alu_frame_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
//   Shared definitions for the UART-to-ALU frame controller.
//   - state_e : controller states; each encoding is also the one-hot value
//               driven on o_flags.
//   - STAT_*  : bit positions inside the 4-bit ALU status word.
package uart_alu_pkg;

  typedef enum logic [4:0] {
    ST_WAIT_A  = 5'b00001,
    ST_WAIT_B  = 5'b00010,
    ST_WAIT_OP = 5'b00100,
    ST_EXEC    = 5'b01000,
    ST_SEND    = 5'b10000
  } state_e;

  localparam int unsigned STAT_ZERO  = 32'd0;
  localparam int unsigned STAT_NEG   = 32'd1;
  localparam int unsigned STAT_CARRY = 32'd2;
  localparam int unsigned STAT_OVF   = 32'd3;

endpackage

// File: rtl/uart_alu_timeout_cnt.sv
// uart_alu_timeout_cnt
//   Inter-byte timeout counter for partially received frames.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_clr      : clear the count (a byte was popped)
//     i_en       : count this cycle (waiting for a byte, FIFO empty)
//     o_expire   : combinational, high on the cycle whose count reaches
//                  TIMEOUT_CYCLES; the count clears on that edge
module uart_alu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Value held just before the increment that would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear (pop) wins over expiry, so expiry is only raised while counting.
  assign o_expire = i_en && (cnt_q == LAST_CNT);

  // Next-count selection.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expire) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl
//   Pops operand A, operand B and opcode from the RX FIFO, presents them to a
//   combinational ALU, latches the result and streams it LSB-first into the
//   TX FIFO. Partially received frames are dropped after TIMEOUT_CYCLES idle
//   cycles (0 = never).
//   Optional build macro UART_ALU_STATUS_BYTE_EN: append one byte carrying
//   the latched ALU status after the result bytes.
//   Ports:
//     clk, i_reset          : clock, asynchronous active-low reset
//     i_rx_data/i_rx_empty  : RX FIFO head (first-word-fall-through)
//     o_rd                  : RX pop strobe
//     i_tx_full/o_wr/o_tx_data : TX FIFO push interface
//     o_op_a/o_op_b/o_opcode   : held ALU operands
//     i_alu_result/i_alu_status : ALU outputs
//     o_flags               : one-hot state, o_timeout : abort pulse,
//     o_busy                : not in WAIT_A
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int BUS_SIZE       = 8,
  parameter int OP_WIDTH       = 6,
  parameter int RES_BYTES      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [BUS_SIZE-1:0]           i_rx_data,
  input  logic                          i_rx_empty,
  output logic                          o_rd,
  input  logic                          i_tx_full,
  output logic                          o_wr,
  output logic [BUS_SIZE-1:0]           o_tx_data,
  output logic [BUS_SIZE-1:0]           o_op_a,
  output logic [BUS_SIZE-1:0]           o_op_b,
  output logic [OP_WIDTH-1:0]           o_opcode,
  input  logic [BUS_SIZE*RES_BYTES-1:0] i_alu_result,
  input  logic [3:0]                    i_alu_status,
  output logic [4:0]                    o_flags,
  output logic                          o_timeout,
  output logic                          o_busy
);

  localparam int RES_W = BUS_SIZE * RES_BYTES;
`ifdef UART_ALU_STATUS_BYTE_EN
  localparam int N_BYTES = RES_BYTES + 1;
`else
  localparam int N_BYTES = RES_BYTES;
`endif
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_e              state_q, state_d;
  logic [BUS_SIZE-1:0] op_a_q, op_a_d;
  logic [BUS_SIZE-1:0] op_b_q, op_b_d;
  logic [OP_WIDTH-1:0] opcode_q, opcode_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                timeout_q, timeout_d;
  logic [3:0]          status_s;
  logic                rd_s, wr_s, cnt_en_s, expire_s;
  logic [BUS_SIZE-1:0] byte_s [16];

  assign status_s = {i_alu_status[STAT_OVF], i_alu_status[STAT_CARRY],
                     i_alu_status[STAT_NEG], i_alu_status[STAT_ZERO]};

`ifdef UART_ALU_STATUS_BYTE_EN
  logic [3:0] status_q, status_d;
`else
  logic unused_status_s;
  assign unused_status_s = ^status_s;
`endif

  // Gated by reset so a byte at the FIFO head is not popped and lost while
  // the controller is held in reset.
  assign rd_s = i_reset && !i_rx_empty &&
                ((state_q == ST_WAIT_A) || (state_q == ST_WAIT_B) ||
                 (state_q == ST_WAIT_OP));
  assign wr_s = (state_q == ST_SEND) && !i_tx_full;
  assign cnt_en_s = ((state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP)) && i_rx_empty;

  // Byte lane table indexed by the send index; unused lanes read as zero.
  for (genvar g = 0; g < 16; g++) begin : g_byte
    if (g < RES_BYTES) begin : g_res
      assign byte_s[g] = result_q[g*BUS_SIZE +: BUS_SIZE];
    end
`ifdef UART_ALU_STATUS_BYTE_EN
    else if (g == RES_BYTES) begin : g_stat
      assign byte_s[g] = BUS_SIZE'(status_q);
    end
`endif
    else begin : g_pad
      assign byte_s[g] = '0;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    uart_alu_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (i_reset),
      .i_clr   (rd_s),
      .i_en    (cnt_en_s),
      .o_expire(expire_s)
    );
  end else begin : g_no_timeout
    logic unused_cnt_s;
    assign unused_cnt_s = cnt_en_s;
    assign expire_s = 1'b0;
  end

  // Next-state and datapath load selection.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opcode_d  = opcode_q;
    result_d  = result_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
`ifdef UART_ALU_STATUS_BYTE_EN
    status_d  = status_q;
`endif
    case (state_q)
      ST_WAIT_A: begin
        if (rd_s) begin
          op_a_d  = i_rx_data;
          state_d = ST_WAIT_B;
        end else begin
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (rd_s) begin
          op_b_d  = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (expire_s) begin
          state_d   = ST_WAIT_A;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (rd_s) begin
          opcode_d = i_rx_data[OP_WIDTH-1:0];
          state_d  = ST_EXEC;
        end else if (expire_s) begin
          state_d   = ST_WAIT_A;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_WAIT_OP;
        end
      end
      ST_EXEC: begin
        result_d = i_alu_result;
`ifdef UART_ALU_STATUS_BYTE_EN
        status_d = status_s;
`endif
        idx_d    = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (wr_s) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_WAIT_A;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_WAIT_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      opcode_q  <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
`ifdef UART_ALU_STATUS_BYTE_EN
      status_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opcode_q  <= opcode_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
`ifdef UART_ALU_STATUS_BYTE_EN
      status_q  <= status_d;
`endif
    end
  end

  assign o_rd      = rd_s;
  assign o_wr      = wr_s;
  assign o_tx_data = wr_s ? byte_s[idx_q] : '0;
  assign o_op_a    = op_a_q;
  assign o_op_b    = op_b_q;
  assign o_opcode  = opcode_q;
  assign o_flags   = state_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != ST_WAIT_A);

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb_uart_alu_frame_ctrl
//   Self-checking bench for uart_alu_frame_ctrl (RES_BYTES=4, TIMEOUT_CYCLES=10).
//   An RX FIFO is modelled as a queue; each frame's expected TX byte stream,
//   write latency and timeout cycle are computed from the frame contents.
module tb_uart_alu_frame_ctrl;

  localparam int BUS = 8;
  localparam int OPW = 6;
  localparam int RB  = 4;
  localparam int TO  = 10;
`ifdef UART_ALU_STATUS_BYTE_EN
  localparam int NB = RB + 1;
`else
  localparam int NB = RB;
`endif

  logic            clk;
  logic            i_reset;
  logic [BUS-1:0]  i_rx_data;
  logic            i_rx_empty;
  logic            o_rd;
  logic            i_tx_full;
  logic            o_wr;
  logic [BUS-1:0]  o_tx_data;
  logic [BUS-1:0]  o_op_a;
  logic [BUS-1:0]  o_op_b;
  logic [OPW-1:0]  o_opcode;
  logic [BUS*RB-1:0] i_alu_result;
  logic [3:0]      i_alu_status;
  logic [4:0]      o_flags;
  logic            o_timeout;
  logic            o_busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] rx_q[$];

  uart_alu_frame_ctrl #(
    .BUS_SIZE(BUS), .OP_WIDTH(OPW), .RES_BYTES(RB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
    .o_rd(o_rd), .i_tx_full(i_tx_full), .o_wr(o_wr), .o_tx_data(o_tx_data),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_opcode(o_opcode),
    .i_alu_result(i_alu_result), .i_alu_status(i_alu_status),
    .o_flags(o_flags), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present the FIFO head; data is garbage while empty.
  task automatic drive_rx();
    i_rx_empty = (rx_q.size() == 0);
    i_rx_data  = i_rx_empty ? 8'($urandom) : rx_q[0];
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_tx_full = 1'b0; i_alu_result = '0; i_alu_status = 4'h0;
    rx_q.delete(); rx_q.push_back(8'hA5); drive_rx();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_flags !== 5'b00001) begin failures++; $display("FAIL reset_flags: got %b expected 00001", o_flags); end
    checks++; if (o_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b expected 0", o_rd); end
    checks++; if ({o_wr, o_tx_data, o_timeout, o_busy} !== 11'd0) begin failures++; $display("FAIL reset_tx: got wr=%b data=%h to=%b busy=%b expected all 0", o_wr, o_tx_data, o_timeout, o_busy); end
    checks++; if ({o_op_a, o_op_b, o_opcode} !== 22'd0) begin failures++; $display("FAIL reset_ops: got %h %h %h expected 0", o_op_a, o_op_b, o_opcode); end
    rx_q.delete(); drive_rx();
    @(posedge clk); #1;
    i_reset = 1'b1;
  endtask

  // One complete frame: byte k arrives k*gap cycles after the first, TX is
  // full for the first full_n SEND cycles.
  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opb, input logic [31:0] res,
                           input logic [3:0] st, input int gap, input int full_n);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int wr_cyc[$];
    int pops = 0, op_cyc = -1, full_left = full_n, to_seen = 0, bp_bad = 0, rd_bad = 0;
    logic rd;
    logic [7:0] g;
    bit done = 1'b0;
    for (int i = 0; i < RB; i++) exp_q.push_back(res[8*i +: 8]);
`ifdef UART_ALU_STATUS_BYTE_EN
    exp_q.push_back({4'h0, st});
`endif
    i_alu_result = res; i_alu_status = st; i_tx_full = (full_n > 0);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc == 0) rx_q.push_back(a);
      if (cyc == gap) rx_q.push_back(b);
      if (cyc == 2*gap) rx_q.push_back(opb);
      drive_rx();
      @(negedge clk);
      if (o_timeout) to_seen++;
      if (o_rd && i_rx_empty) rd_bad++;
      if (o_flags == 5'b10000 && i_tx_full) begin
        if (o_wr !== 1'b0) bp_bad++;
        full_left--;
      end
      if (o_wr === 1'b1) begin
        got_q.push_back(o_tx_data); wr_cyc.push_back(cyc);
        i_alu_result = {$urandom};  // result must already be latched
        if (got_q.size() == exp_q.size()) done = 1'b1;
      end
      rd = o_rd;
      @(posedge clk); #1;
      if (rd && rx_q.size() > 0) begin
        pops++;
        if (pops == 3) op_cyc = cyc;
        void'(rx_q.pop_front());
      end
      if (full_left <= 0) i_tx_full = 1'b0;
    end
    @(negedge clk);
    checks++; if (!done) begin failures++; $display("FAIL %s_done: got %0d writes expected %0d", name, got_q.size(), exp_q.size()); end
    checks++; if (pops !== 3 || rd_bad !== 0) begin failures++; $display("FAIL %s_pops: got %0d pops (%0d while empty) expected 3", name, pops, rd_bad); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL %s_byte%0d: got %h expected %h", name, i, g, exp_q[i]); end
    end
    checks++;
    if (wr_cyc.size() == 0 || wr_cyc[0] != op_cyc + 2 + full_n || wr_cyc[wr_cyc.size()-1] - wr_cyc[0] != NB - 1) begin
      failures++; $display("FAIL %s_latency: first write cyc %0d last %0d expected %0d..%0d", name,
                           (wr_cyc.size() > 0) ? wr_cyc[0] : -1, (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -1,
                           op_cyc + 2 + full_n, op_cyc + 1 + full_n + NB);
    end
    checks++; if (bp_bad !== 0 || to_seen !== 0) begin failures++; $display("FAIL %s_stall: got %0d writes while full, %0d timeouts expected 0", name, bp_bad, to_seen); end
    checks++; if (o_op_a !== a || o_op_b !== b || o_opcode !== opb[OPW-1:0]) begin failures++; $display("FAIL %s_ops: got %h %h %h expected %h %h %h", name, o_op_a, o_op_b, o_opcode, a, b, opb[OPW-1:0]); end
    checks++; if (o_flags !== 5'b00001 || o_busy !== 1'b0) begin failures++; $display("FAIL %s_idle: got flags %b busy %b expected 00001 0", name, o_flags, o_busy); end
    @(posedge clk); #1;
  endtask

  // Send only nbytes of a frame and expect abort TO+1 cycles after the last pop.
  task automatic test_timeout(input string name, input int nbytes);
    logic [7:0] a, b;
    int last_pop = -1, to_cyc = -1, to_cnt = 0, pops = 0;
    logic [4:0] flags_at_to = 5'h0;
    logic rd;
    a = 8'($urandom); b = 8'($urandom);
    rx_q.push_back(a);
    if (nbytes == 2) rx_q.push_back(b);
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive_rx();
      @(negedge clk);
      if (o_timeout === 1'b1) begin
        to_cnt++;
        if (to_cyc < 0) begin to_cyc = cyc; flags_at_to = o_flags; end
      end
      rd = o_rd;
      @(posedge clk); #1;
      if (rd && rx_q.size() > 0) begin pops++; last_pop = cyc; void'(rx_q.pop_front()); end
    end
    checks++; if (pops !== nbytes) begin failures++; $display("FAIL %s_pops: got %0d expected %0d", name, pops, nbytes); end
    checks++; if (to_cyc !== last_pop + TO + 1 || to_cnt !== 1) begin failures++; $display("FAIL %s_pulse: got cycle %0d count %0d expected cycle %0d count 1", name, to_cyc, to_cnt, last_pop + TO + 1); end
    checks++; if (flags_at_to !== 5'b00001) begin failures++; $display("FAIL %s_state: got %b expected 00001", name, flags_at_to); end
    checks++; if (o_op_a !== a || (nbytes == 2 && o_op_b !== b)) begin failures++; $display("FAIL %s_keep: got %h %h expected %h %h", name, o_op_a, o_op_b, a, b); end
  endtask

  task automatic test_reset_mid_send();
    int wrs = 0, late = 0;
    logic [31:0] res;
    res = $urandom;
    i_alu_result = res; i_tx_full = 1'b0;
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
    for (int cyc = 0; cyc < 30 && wrs < 2; cyc++) begin
      drive_rx();
      @(negedge clk);
      if (o_wr === 1'b1) wrs++;
      @(posedge clk); #1;
      if (o_rd === 1'b1 && rx_q.size() > 0) void'(rx_q.pop_front());
    end
    rx_q.delete(); drive_rx();
    i_reset = 1'b0;
    #1;
    checks++; if (wrs !== 2) begin failures++; $display("FAIL rst_send_writes: got %0d expected 2", wrs); end
    checks++; if (o_flags !== 5'b00001 || o_busy !== 1'b0) begin failures++; $display("FAIL rst_send_state: got %b busy %b expected 00001 0", o_flags, o_busy); end
    checks++; if ({o_wr, o_tx_data, o_op_a, o_op_b, o_opcode} !== 31'd0) begin failures++; $display("FAIL rst_send_outs: got wr=%b %h %h %h %h expected 0", o_wr, o_tx_data, o_op_a, o_op_b, o_opcode); end
    repeat (2) @(posedge clk);
    #1; i_reset = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (o_wr !== 1'b0) late++;
    end
    checks++; if (late !== 0) begin failures++; $display("FAIL rst_send_after: got %0d writes expected 0", late); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    run_frame("basic", 8'h05, 8'h03, 8'h20, 32'h0000_0008, 4'h0, 0, 0);
    run_frame("multibyte", 8'h12, 8'h34, 8'h01, 32'h0000_BEEF, 4'h2, 0, 0);
    run_frame("backpressure", 8'h7F, 8'h80, 8'h3F, 32'hCAFE_1234, 4'h8, 0, 4);
    run_frame("pop_wins", 8'hA1, 8'hB2, 8'hC3, 32'h0102_0304, 4'h4, TO, 0);
    run_frame("status", 8'h00, 8'h00, 8'h05, 32'h0000_0000, 4'b0001, 0, 0);
    test_timeout("timeout_b", 1);
    test_timeout("timeout_op", 2);
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom, 4'($urandom), $urandom_range(0, TO), $urandom_range(0, 5));
    end
    test_reset_mid_send();
    run_frame("after_reset", 8'h5A, 8'hA5, 8'h15, 32'hDEAD_BEEF, 4'hF, 2, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
